state_byte_sreg: RTL and testbench

//  Byte-serial masked AES state register; sits directly downstream of the byte-wide state-input mux.
//  - Mux output (plaintext byte or round-function byte) enters at state index 15.
//  - Byte at index 0 is presented to the masked S-box datapath.
//  - Applies ShiftRows in place in one cycle. Each share is held in its own register bank.

---
 rtl/state_byte_sreg_if.sv | 29 ++
 rtl/state_byte_sreg.sv | 149 ++++++++++++++
 tb/tb_state_byte_sreg.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/state_byte_sreg_if.sv
// Byte-stream bundle for the masked AES state register: share-packed input
// bytes with valid/ready, and the share-packed state byte at index 0.
interface state_byte_sreg_if #(
    parameter int SHARES = 2
);
    logic [8*SHARES-1:0] din;
    logic                din_valid;
    logic                din_ready;
    logic [8*SHARES-1:0] dout;
    logic                dout_valid;

    // Upstream side: state-input mux feeding bytes, S-box datapath consuming them.
    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  dout_valid
    );

    // Block side: the state register itself.
    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output dout_valid
    );
endinterface

// File: rtl/state_byte_sreg.sv
// Byte-serial masked AES state register.
// New bytes enter at state index 15, index 0 feeds the masked S-box, and
// ShiftRows is applied in place in a single cycle. Each Boolean share lives
// in its own register bank and shares are never combined.
// Optional feature macro: STATE_SREG_PAR_OUT_EN adds the state_par port,
// a parallel view of every stored byte of every share.
module state_byte_sreg #(
    parameter int SHARES = 2,
    parameter int NBYTES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic       sr_en,
    output logic [3:0] byte_cnt,
    output logic       full,
    state_byte_sreg_if.slave bus
`ifdef STATE_SREG_PAR_OUT_EN
    ,
    output logic [128*SHARES-1:0] state_par
`endif
);

    // The ShiftRows index mapping and the 4-bit byte counter assume a 16-byte state.
    generate
        if (NBYTES != 16) begin : g_bad_nbytes
            $error("state_byte_sreg: NBYTES must be 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state;
    logic       accept_en;
    logic       dout_valid_q;
    logic       do_sr;
    logic       do_shift;

    // st[k][i]: share k, state byte i = 4*col + row (column-major)
    logic [7:0] st [SHARES][NBYTES];

    // ShiftRows steals the cycle in RUN, so input is refused while sr_en is high.
    assign bus.din_ready  = accept_en && !((state == RUN) && sr_en);
    assign bus.dout_valid = dout_valid_q;

    assign do_sr    = !clear && (state == RUN) && sr_en;
    assign do_shift = !clear && bus.din_valid && bus.din_ready;

    // Control FSM: state, byte counter and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= 4'd0;
            full         <= 1'b0;
            dout_valid_q <= 1'b0;
            accept_en    <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            byte_cnt     <= 4'd0;
            full         <= 1'b0;
            dout_valid_q <= 1'b0;
            accept_en    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        byte_cnt  <= 4'd0;
                        accept_en <= 1'b1;
                    end
                end
                FILL: begin
                    if (do_shift) begin
                        byte_cnt <= byte_cnt + 4'd1;
                        if (byte_cnt == 4'd15) begin
                            state        <= RUN;
                            full         <= 1'b1;
                            dout_valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (do_shift) begin
                        byte_cnt <= byte_cnt + 4'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    byte_cnt     <= 4'd0;
                    full         <= 1'b0;
                    dout_valid_q <= 1'b0;
                    accept_en    <= 1'b0;
                end
            endcase
        end
    end

    // State storage: ShiftRows in place, or shift one byte toward index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHARES; k++) begin
                for (int i = 0; i < NBYTES; i++) begin
                    st[k][i] <= 8'h00;
                end
            end
        end else if (do_sr) begin
            for (int k = 0; k < SHARES; k++) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        st[k][4*c+r] <= st[k][4*((c+r)%4)+r];
                    end
                end
            end
        end else if (do_shift) begin
            for (int k = 0; k < SHARES; k++) begin
                for (int i = 0; i < NBYTES-1; i++) begin
                    st[k][i] <= st[k][i+1];
                end
                st[k][NBYTES-1] <= bus.din[8*k +: 8];
            end
        end
    end

    // Output byte is wired straight from the index-0 registers of each share.
    always_comb begin
        bus.dout = '0;
        for (int k = 0; k < SHARES; k++) begin
            bus.dout[8*k +: 8] = st[k][0];
        end
    end

`ifdef STATE_SREG_PAR_OUT_EN
    // Parallel view of the stored state, share k byte i at [128k+8i +: 8].
    always_comb begin
        state_par = '0;
        for (int k = 0; k < SHARES; k++) begin
            for (int i = 0; i < NBYTES; i++) begin
                state_par[128*k + 8*i +: 8] = st[k][i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_state_byte_sreg.sv
// Directed bench for state_byte_sreg: fill, ShiftRows, streaming, clear,
// priority cases and asynchronous reset, against hand-computed values.
module tb_state_byte_sreg;

    localparam int SHARES = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       clear;
    logic       sr_en;
    logic [3:0] byte_cnt;
    logic       full;
`ifdef STATE_SREG_PAR_OUT_EN
    logic [128*SHARES-1:0] state_par;
`endif

    int n_checks;
    int n_pass;

    // ShiftRows of a state holding st[i] = i, read out from index 0 upward
    logic [7:0] sr_exp [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

    state_byte_sreg_if #(.SHARES(SHARES)) bus ();

    state_byte_sreg #(.SHARES(SHARES), .NBYTES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clear    (clear),
        .sr_en    (sr_en),
        .byte_cnt (byte_cnt),
        .full     (full),
        .bus      (bus)
`ifdef STATE_SREG_PAR_OUT_EN
        ,
        .state_par(state_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_sr();
        sr_en = 1'b1;
        tick();
        sr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] e;
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        start         = 1'b0;
        clear         = 1'b0;
        sr_en         = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_dout", bus.dout, 16'h0000);
        check("rst_dout_valid", bus.dout_valid, 1'b0);
        check("rst_din_ready", bus.din_ready, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_byte_cnt", byte_cnt, 4'd0);

        // Fill with 0x00..0x0F, share1 = 0
        pulse_start();
        check("fill_din_ready", bus.din_ready, 1'b1);
        check("fill_dout_valid", bus.dout_valid, 1'b0);
        for (int i = 0; i < 15; i++) push({8'h00, 8'(i)});
        check("fill15_full", full, 1'b0);
        check("fill15_byte_cnt", byte_cnt, 4'd15);
        push(16'h000F);
        check("fill16_full", full, 1'b1);
        check("fill16_dout_valid", bus.dout_valid, 1'b1);
        check("fill16_dout", bus.dout, 16'h0000);
        check("fill16_byte_cnt", byte_cnt, 4'd0);

        // sr_en together with a valid byte: only ShiftRows happens
        sr_en         = 1'b1;
        bus.din       = 16'h7777;
        bus.din_valid = 1'b1;
        #1;
        check("sr_din_ready", bus.din_ready, 1'b0);
        tick();
        sr_en         = 1'b0;
        bus.din_valid = 1'b0;
        check("sr_byte_cnt", byte_cnt, 4'd0);

        // Drain the ShiftRows result; a start pulse in RUN must do nothing
        for (int i = 0; i < 16; i++) begin
            check($sformatf("sr_out%0d", i), bus.dout, {8'h00, sr_exp[i]});
            if (i == 3) start = 1'b1;
            push(16'h0000);
            start = 1'b0;
        end
        check("run_byte_cnt_wrap", byte_cnt, 4'd0);
        check("run_dout_valid", bus.dout_valid, 1'b1);
        check("run_full", full, 1'b1);

        // Share independence: 0xA5 / 0x5A everywhere
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 16; i++) push(16'h5AA5);
        pulse_sr();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("a55a_out%0d", i), bus.dout, 16'h5AA5);
            push(16'h0000);
        end

        // Distinct per-share patterns, streamed in while in RUN
        for (int i = 0; i < 16; i++) push({8'(i << 4), 8'(i)});
        pulse_sr();
        for (int i = 0; i < 16; i++) begin
            e = sr_exp[i];
            check($sformatf("share_out%0d", i), bus.dout, {e[3:0], 4'h0, e});
            push(16'h0000);
        end

        // Clear mid-FILL, then a complete refill
        pulse_clear();
        pulse_start();
        for (int i = 0; i < 7; i++) push({8'h00, 8'(8'h30 + i)});
        check("fill7_byte_cnt", byte_cnt, 4'd7);
        pulse_clear();
        check("clr_byte_cnt", byte_cnt, 4'd0);
        check("clr_din_ready", bus.din_ready, 1'b0);
        check("clr_full", full, 1'b0);
        check("clr_dout_valid", bus.dout_valid, 1'b0);
        push(16'hEEEE);
        check("idle_no_shift", bus.dout, 16'h0000);
        pulse_start();
        for (int i = 0; i < 15; i++) push({8'h00, 8'(8'h20 + i)});
        check("refill15_full", full, 1'b0);
        push(16'h002F);
        check("refill16_full", full, 1'b1);
        check("refill16_dout", bus.dout, 16'h0020);

        // Clear keeps the stored bytes
        pulse_clear();
        check("clr_retain_dout", bus.dout, 16'h0020);

        // Asynchronous reset in the middle of FILL
        pulse_start();
        push(16'h1111);
        push(16'h2222);
        check("prerst_dout", bus.dout, 16'h0022);
        rst = 1'b1;
        #1;
        check("arst_dout", bus.dout, 16'h0000);
        check("arst_byte_cnt", byte_cnt, 4'd0);
        check("arst_din_ready", bus.din_ready, 1'b0);
        check("arst_full", full, 1'b0);
        check("arst_dout_valid", bus.dout_valid, 1'b0);
`ifdef STATE_SREG_PAR_OUT_EN
        check("arst_state_par_lo", state_par[63:0], 64'h0);
        check("arst_state_par_hi", state_par[255:192], 64'h0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check("postrst_din_ready", bus.din_ready, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
